// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    // One radix-2 step per operand bit, so the iteration count equals the width.
    localparam int MD_ITERS = 32;

    localparam logic [63:0] DIV0_Q = '1;

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bus of the multiply/divide unit: launch, MTHI/MTLO and HI/LO readout.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, A, B, hi_we, lo_we, wdata,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, A, B, hi_we, lo_we, wdata,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// Combinational radix-2 step shared by shift-and-add multiply and restoring divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opd,
    input  logic               i_bit,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem;

    // Divide layout: remainder in the upper half, quotient bits enter the lower half.
    assign w_trial = {i_acc[2*WIDTH-1:WIDTH], i_bit};
    assign w_diff  = w_trial - {1'b0, i_opd};
    assign w_ge    = (w_trial >= {1'b0, i_opd});
    assign w_rem   = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    always_comb begin
        o_acc = {i_acc[2*WIDTH-2:0], 1'b0} + (i_bit ? {{WIDTH{1'b0}}, i_opd} : '0);
        if (i_div)
            o_acc = {w_rem, i_acc[WIDTH-2:0], w_ge};
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// MULDIV_FAST_MUL_EN: multiplies bypass RUN and use a single-cycle product.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITERS
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd, r_shf, r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_dz, r_busy, r_done;

    logic               w_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem, w_hi, w_lo;
    logic [2*WIDTH-1:0] w_next, w_src, w_prod;

    assign w_sgn   = ~bus.op[0];
    assign w_a_neg = w_sgn & bus.A[WIDTH-1];
    assign w_b_neg = w_sgn & bus.B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag = w_b_neg ? -bus.B : bus.B;

    // r_shf feeds its MSB into each step: multiplier bits for MUL, dividend bits for DIV.
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_opd (r_opd),
        .i_bit (r_shf[WIDTH-1]),
        .i_div (r_div),
        .o_acc (w_next)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign w_src = r_div ? r_acc : {{WIDTH{1'b0}}, r_opd} * {{WIDTH{1'b0}}, r_shf};
`else
    assign w_src = r_acc;
`endif

    assign w_prod = r_neg_q ? -w_src : w_src;
    assign w_quo  = r_dz ? DIV0_Q[WIDTH-1:0]
                         : (r_neg_q ? -w_src[WIDTH-1:0] : w_src[WIDTH-1:0]);
    assign w_rem  = r_neg_r ? -w_src[2*WIDTH-1:WIDTH] : w_src[2*WIDTH-1:WIDTH];
    assign w_hi   = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_lo   = r_div ? w_quo : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_shf   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_div   <= bus.op[1];
                        r_opd   <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_shf   <= bus.op[1] ? w_a_mag : w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dz    <= (bus.B == '0);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        r_state <= bus.op[1] ? S_RUN : S_FIX;
`else
                        r_state <= S_RUN;
`endif
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next;
                    r_shf <= r_shf << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_hi;
                    r_lo    <= w_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results from plain 64-bit arithmetic.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        longint      sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.t0 = 0;
        e.lat = 0;
        e.name = $sformatf("op%0d_%h_%h", op, a, b);
        case (op)
            OP_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            OP_DIV: begin
                if (b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin
                    r = sa / sb; e.lo = r[31:0];
                    r = sa % sb; e.hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
        endcase
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        if (bus.busy) begin
            ntests++; nfail++;
            $display("FAIL wait_idle: busy stuck high, expected low within 100 cycles");
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((q.size() != 0 || bus.busy) && n < 200) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            ntests++; nfail++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        exp_t e;
        wait_idle();
        e = model(op, a, b);
        e.t0 = cyc + 1;
        e.lat = (FAST && !op[1]) ? 1 : 33;
        q.push_back(e);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (q.size() == 0) begin
                    ntests++; nfail++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                    chk({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
                    chk({e.name, "_busy_low"}, 64'(bus.busy), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_MULT,  32'hFFFF_FFFF, 32'd2);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(OP_DIVU,  32'd7, 32'd2);
        issue(OP_DIV,   32'h1234, 32'd0);
        issue(OP_DIVU,  32'h8765_4321, 32'd0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        wait_empty();

        // Stray start and MTHI while busy must both be dropped.
        if (FAST) issue(OP_DIVU, 32'd15, 32'd1);
        else      issue(OP_MULTU, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd9; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        @(negedge clk);
        bus.hi_we = 1'b0;
        wait_empty();
        repeat (2) @(negedge clk);
        chk("ignored_hi", 64'(bus.hi), 64'd0);
        chk("ignored_lo", 64'(bus.lo), 64'd15);

        bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'hBEEF);
        chk("mtlo_hi", 64'(bus.hi), 64'd0);

        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5A5A;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mthilo_hi", 64'(bus.hi), 64'h5A5A);
        chk("mthilo_lo", 64'(bus.lo), 64'h5A5A);

        bus.lo_we = 1'b1; bus.wdata = 32'h1111;
        issue(OP_DIVU, 32'd20, 32'd3);
        bus.lo_we = 1'b0;
        chk("start_wins_lo", 64'(bus.lo), 64'h5A5A);
        wait_empty();

        // Reset mid-operation: no result, no done.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_hi", 64'(bus.hi), 64'd0);
        chk("midrst_lo", 64'(bus.lo), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_busy", 64'(bus.busy), 64'd0);
        chk("postrst_lo", 64'(bus.lo), 64'd0);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_empty();

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                default: ;
            endcase
            issue(rop, ra, rb);
        end
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
